// File: rtl/spike_event_arbiter_if.sv
// Event handshake between the spike arbiter (master) and the shared STDP update engine (slave).
interface spike_event_arbiter_if #(
    parameter int ID_W = 2,
    parameter int TS_W = 8
);
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;
    logic [TS_W-1:0] ev_ts;

    modport master (output ev_valid, ev_id, ev_ts, input ev_ready);
    modport slave  (input ev_valid, ev_id, ev_ts, output ev_ready);
endinterface

// File: rtl/spike_event_arbiter.sv
// Round-robin arbiter that funnels timestamped spike events from N_SRC neurons
// into one STDP update engine through a valid/ready port.

module spike_event_lane #(
    parameter int TS_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cap,
    input  logic            clr,
    input  logic            ovf_clr,
    input  logic [TS_W-1:0] ts_cnt,
    output logic            pending,
    output logic [TS_W-1:0] ts_lat,
    output logic            ovf,
    output logic            drop
);
    // The slot retired by this cycle's handshake can take a new spike at once.
    assign drop = cap && pending && !clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            ts_lat  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (cap && (!pending || clr)) begin
                pending <= 1'b1;
                ts_lat  <= ts_cnt;
            end else if (clr) begin
                pending <= 1'b0;
            end
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end
endmodule

module spike_event_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC),
    parameter int TS_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [N_SRC-1:0]      spike_in,
    input  logic                  ovf_clr,
    spike_event_arbiter_if.master ev,
    output logic [N_SRC-1:0]      ovf_flags,
    output logic [7:0]            drop_cnt,
    output logic                  busy
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_nxt;

    logic [TS_W-1:0]             ts_cnt;
    logic [ID_W-1:0]             rr_ptr;
    logic [N_SRC-1:0]            pending, drop, clr;
    logic [N_SRC-1:0][TS_W-1:0]  ts_lat;
    logic                        hs;
    logic                        found;
    logic [ID_W-1:0]             pick;
    logic [ID_W:0]               wrap_sum;
    logic [3:0]                  n_drop;
    logic [8:0]                  drop_sum;
    logic [7:0]                  drop_nxt;

    assign hs   = ev.ev_valid && ev.ev_ready;
    assign busy = (|pending) || ev.ev_valid;

    for (genvar i = 0; i < N_SRC; i++) begin : g_lane
        assign clr[i] = hs && (ev.ev_id == ID_W'(i));
        spike_event_lane #(.TS_W(TS_W)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .cap     (ena && spike_in[i]),
            .clr     (clr[i]),
            .ovf_clr (ovf_clr),
            .ts_cnt  (ts_cnt),
            .pending (pending[i]),
            .ts_lat  (ts_lat[i]),
            .ovf     (ovf_flags[i]),
            .drop    (drop[i])
        );
    end

    // First pending source at or above rr_ptr, wrapping past N_SRC-1.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        wrap_sum = '0;
        for (int k = 0; k < N_SRC; k++) begin
            wrap_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (wrap_sum >= (ID_W+1)'(N_SRC)) wrap_sum = wrap_sum - (ID_W+1)'(N_SRC);
            if (!found && pending[wrap_sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = wrap_sum[ID_W-1:0];
            end
        end
    end

    // A clear in the same cycle as drops restarts the count from those drops.
    always_comb begin
        n_drop = '0;
        for (int k = 0; k < N_SRC; k++) n_drop = n_drop + 4'(drop[k]);
        drop_sum = (ovf_clr ? 9'd0 : {1'b0, drop_cnt}) + 9'(n_drop);
        drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = OFFER;
            OFFER:   if (ev.ev_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            ts_cnt      <= '0;
            drop_cnt    <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_id    <= '0;
            ev.ev_ts    <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            if (ena) ts_cnt <= ts_cnt + TS_W'(1);
            if (state == IDLE && found) begin
                ev.ev_valid <= 1'b1;
                ev.ev_id    <= pick;
                ev.ev_ts    <= ts_lat[pick];
            end else if (state == OFFER && hs) begin
                ev.ev_valid <= 1'b0;
                rr_ptr      <= (ev.ev_id == ID_W'(N_SRC-1)) ? '0 : ev.ev_id + ID_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_spike_event_arbiter.sv
// Scoreboard bench for spike_event_arbiter: expected (id, ts) pairs are queued at stimulus
// time and popped by a handshake monitor; scenario tasks add inline checks.
module tb_spike_event_arbiter;
    localparam int N_SRC = 4;
    localparam int ID_W  = 2;
    localparam int TS_W  = 8;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset, ena, ovf_clr, busy;
    logic [N_SRC-1:0] spike_in, ovf_flags;
    logic [7:0]       drop_cnt;
    logic [TS_W-1:0]  m_ts;
    ev_t              exp_q[$];
    int               checks = 0;
    int               failures = 0;

    spike_event_arbiter_if #(.ID_W(ID_W), .TS_W(TS_W)) bus ();

    spike_event_arbiter #(.N_SRC(N_SRC), .ID_W(ID_W), .TS_W(TS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .spike_in  (spike_in),
        .ovf_clr   (ovf_clr),
        .ev        (bus),
        .ovf_flags (ovf_flags),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts enabled cycles since reset.
    always @(posedge clk) begin
        if (reset)    m_ts <= '0;
        else if (ena) m_ts <= m_ts + 8'd1;
    end

    // Handshake monitor: a transfer happens on the edge following this sample.
    always @(negedge clk) begin
        ev_t e;
        if (!reset && bus.ev_valid && bus.ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got id=%0d ts=%0d, queue empty", bus.ev_id, bus.ev_ts);
            end else begin
                e = exp_q.pop_front();
                if (bus.ev_id !== e.id || bus.ev_ts !== e.ts) begin
                    failures++;
                    $display("FAIL sb_event got id=%0d ts=%0d exp id=%0d ts=%0d",
                             bus.ev_id, bus.ev_ts, e.id, e.ts);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ena = 1'b1; spike_in = '0; ovf_clr = 1'b0; bus.ev_ready = 1'b0;
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ev_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset_latency();
        bit ok;
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.ev_valid, bus.ev_id, bus.ev_ts, ovf_flags, drop_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b id=%0d ts=%0d ovf=%b drop=%0d exp all 0",
                     bus.ev_valid, bus.ev_id, bus.ev_ts, ovf_flags, drop_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        for (int i = 0; i < 20 && m_ts != 8'd5; i++) tick();
        spike_in = 4'b0100;
        exp_q.push_back('{id: 2'd2, ts: 8'd5});
        tick();
        spike_in = '0;
        @(negedge clk);
        checks++;
        if (bus.ev_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL latency_k got valid=%b busy=%b exp valid=0 busy=1", bus.ev_valid, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.ev_valid !== 1'b1 || bus.ev_id !== 2'd2 || bus.ev_ts !== 8'd5) begin
            failures++;
            $display("FAIL latency_k1 got v=%b id=%0d ts=%0d exp v=1 id=2 ts=5",
                     bus.ev_valid, bus.ev_id, bus.ev_ts);
        end
        tick();
        bus.ev_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL latency_drain got %0d left exp 0", exp_q.size()); end
        tick();
        bus.ev_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL latency_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [6:0] vpat;
        do_reset();
        spike_in = 4'b1011;
        bus.ev_ready = 1'b1;
        exp_q.push_back('{id: 2'd0, ts: m_ts});
        exp_q.push_back('{id: 2'd1, ts: m_ts});
        exp_q.push_back('{id: 2'd3, ts: m_ts});
        vpat = '0;
        for (int c = 0; c < 7; c++) begin
            tick();
            spike_in = '0;
            @(negedge clk);
            vpat[c] = bus.ev_valid;
        end
        checks++;
        if (vpat !== 7'b0101010) begin
            failures++;
            $display("FAIL rr_spacing got %b exp 0101010", vpat);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rr_count got %0d left exp 0", exp_q.size()); end
        tick();
        spike_in = 4'b0001;
        exp_q.push_back('{id: 2'd0, ts: m_ts});
        tick();
        spike_in = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_wrap_drain got %0d left exp 0", exp_q.size()); end
        tick();
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_hold_overflow();
        bit ok;
        logic [TS_W-1:0] t;
        do_reset();
        tick();
        spike_in = 4'b0010;
        t = m_ts;
        exp_q.push_back('{id: 2'd1, ts: t});
        tick();
        spike_in = '0;
        wait_valid(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL hold_valid got valid=%b exp 1", bus.ev_valid); end
        for (int i = 0; i < 10; i++) begin
            tick();
            spike_in = (i == 3) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            checks++;
            if (bus.ev_valid !== 1'b1 || bus.ev_id !== 2'd1 || bus.ev_ts !== t) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got v=%b id=%0d ts=%0d exp v=1 id=1 ts=%0d",
                         i, bus.ev_valid, bus.ev_id, bus.ev_ts, t);
            end
        end
        tick();
        spike_in = '0;
        @(negedge clk);
        checks++;
        if (ovf_flags !== 4'b0010 || drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL hold_drop got ovf=%b drop=%0d exp ovf=0010 drop=1", ovf_flags, drop_cnt);
        end
        tick();
        bus.ev_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL hold_drain got %0d left exp 0", exp_q.size()); end
        tick();
        bus.ev_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got %b exp 0", busy); end
    endtask

    task automatic test_recapture();
        bit ok;
        do_reset();
        tick(); tick();
        spike_in = 4'b1000;
        exp_q.push_back('{id: 2'd3, ts: m_ts});
        tick();
        spike_in = '0;
        wait_valid(ok);
        tick();
        bus.ev_ready = 1'b1;
        spike_in = 4'b1000;
        exp_q.push_back('{id: 2'd3, ts: m_ts});
        tick();
        spike_in = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL recap_drain got %0d left exp 0", exp_q.size()); end
        checks++;
        if (drop_cnt !== 8'd0 || ovf_flags !== 4'b0000) begin
            failures++;
            $display("FAIL recap_nodrop got ovf=%b drop=%0d exp 0", ovf_flags, drop_cnt);
        end
        tick();
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_ts_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 300 && m_ts != 8'd255; i++) tick();
        spike_in = 4'b0001;
        exp_q.push_back('{id: 2'd0, ts: 8'd255});
        tick();
        spike_in = 4'b0010;
        exp_q.push_back('{id: 2'd1, ts: 8'd0});
        tick();
        spike_in = '0;
        bus.ev_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_drain got %0d left exp 0", exp_q.size()); end
        tick();
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_ena();
        bit ok;
        do_reset();
        tick(); tick();
        ena = 1'b0;
        spike_in = 4'b0001;
        tick(); tick(); tick();
        spike_in = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ena_ignore got busy=%b exp 0", busy); end
        tick();
        ena = 1'b1;
        spike_in = 4'b0001;
        exp_q.push_back('{id: 2'd0, ts: m_ts});
        bus.ev_ready = 1'b1;
        tick();
        spike_in = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ena_drain got %0d left exp 0", exp_q.size()); end
        tick();
        bus.ev_ready = 1'b0;
    endtask

    task automatic test_drops_and_clear();
        do_reset();
        spike_in = 4'b1111;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd4 || ovf_flags !== 4'b1111) begin
            failures++;
            $display("FAIL multi_drop got ovf=%b drop=%0d exp ovf=1111 drop=4", ovf_flags, drop_cnt);
        end
        for (int i = 1; i < 75; i++) begin
            tick();
            if (i == 62) begin
                @(negedge clk);
                checks++;
                if (drop_cnt !== 8'd252) begin
                    failures++;
                    $display("FAIL drop_252 got %0d exp 252", drop_cnt);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
        tick();
        spike_in = 4'b0100;
        ovf_clr = 1'b1;
        tick();
        spike_in = '0;
        @(negedge clk);
        checks++;
        if (ovf_flags !== 4'b0100 || drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL clr_vs_drop got ovf=%b drop=%0d exp ovf=0100 drop=1", ovf_flags, drop_cnt);
        end
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_flags !== 4'b0000 || drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr got ovf=%b drop=%0d exp 0", ovf_flags, drop_cnt);
        end
        checks++;
        if (bus.ev_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_offer got %b exp 1", bus.ev_valid); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ev_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_offer got valid=%b busy=%b exp 0 0", bus.ev_valid, busy);
        end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; spike_in = '0; ovf_clr = 1'b0; bus.ev_ready = 1'b0;
        test_reset_latency();
        test_round_robin();
        test_hold_overflow();
        test_recapture();
        test_ts_wrap();
        test_ena();
        test_drops_and_clear();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
